song_sequencer: RTL and testbench
=================================

# song_sequencer

Plays a stored melody by sequencing the square-wave tone generator. On a start request it walks a synchronous note ROM of (half-period threshold, duration) entries and drives the generator's enable and threshold for exactly the programmed time per note, with a silent articulation gap between notes. It sits between the top-level controls and the frequency generator on the internal oscillator clock domain.

## Interface

Parameters:
- ADDR_W, 6: note ROM address width (up to 64 entries).
- TICK_DIV, 48000: clk cycles per duration tick, 1 ms at 48 MHz. Must be ≥ 1.
- GAP_TICKS, 20: silent ticks between notes. 0 means no gap.

Ports:
- clk, in, 1: system clock (internal oscillator).
- reset_n, in, 1: reset. One clock; reset is asynchronous and active-low.
- start, in, 1: play request, sampled only in IDLE.
- stop, in, 1: abort request, sampled in every state except IDLE; takes priority over start.
- loop_en, in, 1: restart from entry 0 at end of song.
- rom_addr, out, ADDR_W: note ROM address, registered.
- rom_threshold, in, 32: threshold word, valid the cycle after rom_addr is presented.
- rom_dur, in, 16: duration in ticks, same latency as rom_threshold.
- gen_en, out, 1: tone generator enable.
- gen_threshold, out, 32: tone generator half-period count.
- busy, out, 1: high in every state except IDLE.
- done, out, 1: one-cycle pulse on natural end of song.

## Operation

- Reset values: state IDLE; rom_addr, gen_threshold and tick/cycle counters are 0; gen_en, busy and done are 0.
- IDLE → FETCH on start. rom_addr is set to 0.
- FETCH (1 cycle): rom_addr is held. Next state is LOAD.
- LOAD (1 cycle): rom_threshold and rom_dur are captured.
  - If rom_dur == 0, this is the end marker. Go to END.
  - Otherwise, gen_threshold is set to rom_threshold and gen_en is set to (rom_threshold != 0). A threshold of 0 is a rest. Tick counter and cycle divider are cleared. Next state is PLAY.
- PLAY: the divider counts 0..TICK_DIV-1 and advances the tick counter on wrap.
  - When the tick count reaches the captured duration, gen_en goes low and gen_threshold is held.
  - If GAP_TICKS > 0, go to GAP. Otherwise, go to ADV.
- GAP: gen_en stays low for GAP_TICKS*TICK_DIV cycles, then go to ADV.
- ADV (1 cycle):
  - If rom_addr == 2^ADDR_W-1, go to END. This is the implicit end after the last slot.
  - Otherwise, rom_addr increments. Next state is FETCH.
- END (1 cycle):
  - If loop_en, rom_addr is set to 0. Next state is FETCH. done is not pulsed.
  - Otherwise, done is high for this cycle, gen_en is 0, rom_addr is held, and the next state is IDLE.
- stop in any non-IDLE state:
  - Next edge goes to IDLE, gen_en = 0, and counters are cleared. done is not pulsed.
  - rom_addr and gen_threshold hold their values.
- start while busy is ignored. start and stop high together in IDLE: stay IDLE.
- Counter widths: tick counter 16 bits. Divider is ceil(log2(TICK_DIV)) bits, minimum 1. No overflow is possible because the duration is ≤ 65535 ticks.
- Asynchronous reset mid-note: immediately applies the reset values above, including gen_en = 0.

## Timing

- Start is sampled at edge k:
  - FETCH during cycle k..k+1.
  - LOAD during k+1..k+2.
  - gen_en rises at edge k+2 for a non-rest note.
- Sounding time per note: exactly rom_dur*TICK_DIV cycles, measured from gen_en rise to gen_en fall.
- Inter-note silence: GAP_TICKS*TICK_DIV + 3 cycles (GAP + ADV + FETCH + LOAD), or 3 cycles when GAP_TICKS = 0.
- stop sampled at edge s: gen_en is 0 and busy is 0 after edge s.
- done is asserted for exactly one cycle, after edge e+1 where edge e enters END. busy falls at the same edge the done pulse ends.
- Loop restart: gen_en of entry 0 rises 3 cycles after the END state is entered.

## Test plan

All scenarios use ADDR_W=3, TICK_DIV=4, GAP_TICKS=1.

- Reset then idle:
  - Stimulus: assert reset_n low mid-cycle.
  - Response: all outputs are 0 immediately; start low keeps busy = 0 for 100 cycles.
- Two-note song:
  - Stimulus: ROM {(27272,2),(13636,3),(x,0)}; start.
  - Response: gen_threshold is 27272 with gen_en high for 8 cycles, low for 7 cycles, then 13636 high for 12 cycles. done pulses once; busy then falls.
- Rest entry:
  - Stimulus: ROM {(0,2),(27272,1),(x,0)}.
  - Response: gen_en stays low through entry 0 (8 + 7 cycles), then is high for 4 cycles.
- Loop:
  - Stimulus: same ROM as the two-note song, with loop_en=1.
  - Response: entry 0 replays 3 cycles after END, no done pulse occurs, and rom_addr returns to 0.
- Stop mid-note:
  - Stimulus: assert stop 5 cycles into entry 1.
  - Response: gen_en and busy are 0 next cycle and done stays 0. A new start replays from entry 0.
- Full ROM, no end marker:
  - Stimulus: all 8 entries have dur = 1.
  - Response: after entry 7, ADV goes to END, done pulses once, and rom_addr does not wrap.

Source files
------------

// File: rtl/song_sequencer.sv
// Melody sequencer: walks a synchronous note ROM of (threshold, duration) pairs and
// drives the square-wave generator's enable/threshold with a silent gap between notes.
module song_sequencer #(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned TICK_DIV  = 48000,
  parameter int unsigned GAP_TICKS = 20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_threshold,
  input  logic [15:0]       rom_dur,
  output logic              gen_en,
  output logic [31:0]       gen_threshold,
  output logic              busy,
  output logic              done
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [15:0]       GAP_CNT   = 16'(GAP_TICKS);
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_PLAY  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_ADV   = 3'd5;
  localparam logic [2:0] S_END   = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       thr_q, thr_d;
  logic              en_q, en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [15:0]       tick_q, tick_d;
  logic [15:0]       dur_q, dur_d;
  logic              div_wrap;
  logic [15:0]       tick_next;

  assign div_wrap  = (div_q == DIV_LAST);
  assign tick_next = 16'(tick_q + 16'd1);

  // Next-state and output logic; stop overrides everything outside IDLE.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    thr_d   = thr_q;
    en_d    = en_q;
    div_d   = div_q;
    tick_d  = tick_q;
    dur_d   = dur_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d = S_FETCH;
          addr_d  = '0;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        if (rom_dur == 16'd0) begin
          en_d    = 1'b0;
          state_d = S_END;
        end else begin
          thr_d   = rom_threshold;
          en_d    = |rom_threshold;
          dur_d   = rom_dur;
          div_d   = '0;
          tick_d  = '0;
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (div_wrap) begin
          div_d  = '0;
          tick_d = tick_next;
          if (tick_next == dur_q) begin
            en_d    = 1'b0;
            tick_d  = '0;
            state_d = (GAP_TICKS > 0) ? S_GAP : S_ADV;
          end
        end else begin
          div_d = DIV_W'(div_q + 1'b1);
        end
      end
      S_GAP: begin
        if (div_wrap) begin
          div_d  = '0;
          tick_d = tick_next;
          if (tick_next == GAP_CNT) begin
            tick_d  = '0;
            state_d = S_ADV;
          end
        end else begin
          div_d = DIV_W'(div_q + 1'b1);
        end
      end
      S_ADV: begin
        if (addr_q == ADDR_LAST) begin
          state_d = S_END;
        end else begin
          addr_d  = ADDR_W'(addr_q + 1'b1);
          state_d = S_FETCH;
        end
      end
      S_END: begin
        en_d = 1'b0;
        if (loop_en) begin
          addr_d  = '0;
          state_d = S_FETCH;
        end else begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        en_d    = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    if (stop && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      en_d    = 1'b0;
      div_d   = '0;
      tick_d  = '0;
      addr_d  = addr_q;
      thr_d   = thr_q;
      done_d  = 1'b0;
    end

    // busy stays up through the done cycle so it falls as done ends
    busy_d = (state_d != S_IDLE) || done_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      thr_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div_q   <= '0;
      tick_q  <= '0;
      dur_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      thr_q   <= thr_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      dur_q   <= dur_d;
    end
  end

  assign rom_addr      = addr_q;
  assign gen_threshold = thr_q;
  assign gen_en        = en_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: per-cycle expected output trace built from the song's
// timing rules (note length, gap, fetch/load overhead), compared with assertions.
module tb_song_sequencer;
  localparam int unsigned ADDR_W    = 3;
  localparam int unsigned TICK_DIV  = 4;
  localparam int unsigned GAP_TICKS = 1;
  localparam int unsigned NENT      = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start, stop, loop_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_threshold;
  logic [15:0]       rom_dur;
  logic              gen_en;
  logic [31:0]       gen_threshold;
  logic              busy, done;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] mem_thr [NENT];
  logic [15:0] mem_dur [NENT];

  typedef struct {
    logic        en;
    logic [31:0] thr;
    logic        busy;
    logic        done;
    logic [2:0]  addr;
  } exp_t;

  exp_t        q[$];
  logic [31:0] last_thr  = '0;
  logic [2:0]  last_addr = '0;

  song_sequencer #(.ADDR_W(ADDR_W), .TICK_DIV(TICK_DIV), .GAP_TICKS(GAP_TICKS)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .loop_en(loop_en),
    .rom_addr(rom_addr), .rom_threshold(rom_threshold), .rom_dur(rom_dur),
    .gen_en(gen_en), .gen_threshold(gen_threshold), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // synchronous note ROM: data valid the cycle after the address
  always @(posedge clk) begin
    rom_threshold <= mem_thr[rom_addr];
    rom_dur       <= mem_dur[rom_addr];
  end

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic en, input logic [31:0] thr, input logic b,
                      input logic d, input int a);
    exp_t e;
    e.en = en; e.thr = thr; e.busy = b; e.done = d; e.addr = 3'(a);
    q.push_back(e);
  endtask

  // Expected outputs after each clock edge, starting with the edge that samples start.
  task automatic build(input bit lp, input int cap);
    int          a = 0;
    logic [31:0] t = last_thr;
    bit          fin = 0;
    bit          at_end;
    q.delete();
    push(0, t, 1, 0, a); push(0, t, 1, 0, a);
    while (!fin && q.size() < cap) begin
      at_end = 0;
      if (mem_dur[a] == 16'd0) begin
        at_end = 1;
      end else begin
        t = mem_thr[a];
        repeat (int'(mem_dur[a]) * TICK_DIV) push(t != 0, t, 1, 0, a);
        repeat (GAP_TICKS * TICK_DIV) push(0, t, 1, 0, a);
        push(0, t, 1, 0, a);
        if (a == NENT - 1) at_end = 1;
        else begin
          a++;
          push(0, t, 1, 0, a); push(0, t, 1, 0, a);
        end
      end
      if (at_end) begin
        push(0, t, 1, 0, a);
        if (lp) begin
          a = 0;
          push(0, t, 1, 0, a); push(0, t, 1, 0, a);
        end else begin
          push(0, t, 1, 1, a);
          repeat (3) push(0, t, 0, 0, a);
          fin = 1;
        end
      end
    end
  endtask

  task automatic check_cycle();
    exp_t e;
    e = q.pop_front();
    @(posedge clk); #1;
    cmp("gen_en", 32'(gen_en), 32'(e.en));
    cmp("gen_threshold", gen_threshold, e.thr);
    cmp("busy", 32'(busy), 32'(e.busy));
    cmp("done", 32'(done), 32'(e.done));
    cmp("rom_addr", 32'(rom_addr), 32'(e.addr));
    last_thr  = e.thr;
    last_addr = e.addr;
  endtask

  // Caller sets start before calling; optional stray start pulses while busy.
  task automatic run(input int n, input bit rnd_start);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      if (q.size() == 0) break;
      e = q[0];
      check_cycle();
      start = rnd_start && e.busy && !e.done && ($urandom_range(0, 3) == 0);
    end
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    cmp("stop_gen_en", 32'(gen_en), 32'd0);
    cmp("stop_busy", 32'(busy), 32'd0);
    cmp("stop_done", 32'(done), 32'd0);
    cmp("stop_thr_hold", gen_threshold, last_thr);
    cmp("stop_addr_hold", 32'(rom_addr), 32'(last_addr));
    repeat (3) begin
      @(posedge clk); #1;
      cmp("post_stop_busy", 32'(busy), 32'd0);
      cmp("post_stop_done", 32'(done), 32'd0);
    end
  endtask

  task automatic load_two_note();
    for (int i = 0; i < NENT; i++) begin mem_thr[i] = $urandom; mem_dur[i] = 16'd0; end
    mem_thr[0] = 32'd27272; mem_dur[0] = 16'd2;
    mem_thr[1] = 32'd13636; mem_dur[1] = 16'd3;
  endtask

  task automatic play(input bit rnd_start);
    build(0, 2000);
    start = 1'b1;
    run(q.size(), rnd_start);
  endtask

  task automatic check_all_zero(input string tag);
    cmp({tag, "_gen_en"}, 32'(gen_en), 32'd0);
    cmp({tag, "_thr"}, gen_threshold, 32'd0);
    cmp({tag, "_busy"}, 32'(busy), 32'd0);
    cmp({tag, "_done"}, 32'(done), 32'd0);
    cmp({tag, "_addr"}, 32'(rom_addr), 32'd0);
  endtask

  initial begin
    reset_n = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    for (int i = 0; i < NENT; i++) begin mem_thr[i] = '0; mem_dur[i] = '0; end

    // reset asserted mid-cycle, outputs checked immediately
    @(posedge clk); #2 reset_n = 1'b0; #1;
    check_all_zero("reset");
    @(negedge clk) reset_n = 1'b1;
    repeat (100) begin
      @(posedge clk); #1;
      cmp("idle_busy", 32'(busy), 32'd0);
    end

    // start together with stop in IDLE is ignored
    start = 1'b1; stop = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      cmp("start_stop_idle_busy", 32'(busy), 32'd0);
    end
    start = 1'b0; stop = 1'b0;

    // two-note song, stray start pulses while busy
    load_two_note();
    play(1);

    // rest entry
    for (int i = 0; i < NENT; i++) begin mem_thr[i] = $urandom; mem_dur[i] = 16'd0; end
    mem_thr[0] = 32'd0;     mem_dur[0] = 16'd2;
    mem_thr[1] = 32'd27272; mem_dur[1] = 16'd1;
    play(0);

    // loop: no done, restarts from entry 0, then aborted
    load_two_note();
    loop_en = 1'b1;
    build(1, 70);
    start = 1'b1;
    run(70, 0);
    do_stop();
    loop_en = 1'b0;

    // stop 5 cycles into entry 1, then full replay
    build(0, 2000);
    start = 1'b1;
    run(22, 0);
    do_stop();
    play(0);

    // full ROM without end marker
    for (int i = 0; i < NENT; i++) begin
      mem_thr[i] = 32'($urandom_range(1, 100000)); mem_dur[i] = 16'd1;
    end
    play(0);

    // random songs
    for (int s = 0; s < 8; s++) begin
      int mk;
      mk = $urandom_range(0, NENT);
      for (int i = 0; i < NENT; i++) begin
        mem_thr[i] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
        mem_dur[i] = 16'($urandom_range(1, 3));
        if (i == mk) mem_dur[i] = 16'd0;
      end
      play(1);
    end

    // asynchronous reset in the middle of a sounding note
    load_two_note();
    build(0, 2000);
    start = 1'b1;
    run(5, 0);
    #2 reset_n = 1'b0; #1;
    check_all_zero("midnote_reset");
    last_thr = '0; last_addr = '0;
    @(negedge clk) reset_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      cmp("after_reset_busy", 32'(busy), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
